// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle: stall/flush sources in,
// per-latch enable/flush controls and status out.
interface hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              ihit;
  logic              dhit;
  logic              mem_dreq;
  logic              halt;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [REG_AW-1:0] ex_dest;
  logic              ex_memread;
  logic              br_valid;
  logic              br_mispredict;

  logic              pc_en;
  logic              ifid_en;
  logic              ifid_flush;
  logic              idex_en;
  logic              idex_flush;
  logic              exmem_en;
  logic              exmem_flush;
  logic              memwb_en;
  logic [1:0]        state;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output ihit, dhit, mem_dreq, halt, id_rs, id_rt, id_use_rs, id_use_rt,
           ex_dest, ex_memread, br_valid, br_mispredict,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           exmem_flush, memwb_en, state, stall_cnt, flush_cnt
  );

  modport slave (
    input  ihit, dhit, mem_dreq, halt, id_rs, id_rt, id_use_rs, id_use_rt,
           ex_dest, ex_memread, br_valid, br_mispredict,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           exmem_flush, memwb_en, state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard controller: load-use bubbles, mispredict flush,
// memory/fetch wait stalls, halt freeze, plus stall/flush perf counters.
module hazard_ctrl #(
  parameter int REG_AW         = 5,
  parameter int LU_BUBBLES     = 1,
  parameter int BR_FLUSH_DEPTH = 2,
  parameter int CNT_W          = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  hazard_ctrl_if.slave hz
);
  typedef enum logic [1:0] {RUN = 2'd0, LU_STALL = 2'd1, HALTED = 2'd2} state_e;

  localparam logic [1:0] BUB_INIT   = 2'(LU_BUBBLES - 1);
  localparam logic       EXMEM_KILL = (BR_FLUSH_DEPTH == 3);

  state_e           state_q, state_d;
  logic [1:0]       bub_q, bub_d;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             data_wait, mispredict, lu_hit, flush_evt;

  assign data_wait  = hz.mem_dreq & ~hz.dhit;
  assign mispredict = hz.br_valid & hz.br_mispredict;
  assign lu_hit     = hz.ex_memread && (hz.ex_dest != '0) &&
                      ((hz.id_use_rs && hz.id_rs == hz.ex_dest) ||
                       (hz.id_use_rt && hz.id_rt == hz.ex_dest));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      bub_q   <= '0;
    end else begin
      state_q <= state_d;
      bub_q   <= bub_d;
    end
  end

  always_comb begin
    hz.pc_en       = 1'b1;
    hz.ifid_en     = 1'b1;
    hz.ifid_flush  = 1'b0;
    hz.idex_en     = 1'b1;
    hz.idex_flush  = 1'b0;
    hz.exmem_en    = 1'b1;
    hz.exmem_flush = 1'b0;
    hz.memwb_en    = 1'b1;
    state_d        = state_q;
    bub_d          = bub_q;
    flush_evt      = 1'b0;

    if (!nRST || state_q == HALTED || data_wait) begin
      // full freeze: nothing advances, state and bubble count hold
      hz.pc_en    = 1'b0;
      hz.ifid_en  = 1'b0;
      hz.idex_en  = 1'b0;
      hz.exmem_en = 1'b0;
      hz.memwb_en = 1'b0;
    end else if (mispredict) begin
      hz.ifid_flush  = 1'b1;
      hz.idex_flush  = 1'b1;
      hz.exmem_flush = EXMEM_KILL;
      state_d        = RUN;
      bub_d          = '0;
      flush_evt      = 1'b1;
    end else if (state_q == LU_STALL || lu_hit) begin
      hz.pc_en      = 1'b0;
      hz.ifid_en    = 1'b0;
      hz.idex_flush = 1'b1;
      if (state_q == LU_STALL) begin
        if (bub_q <= 2'd1) begin
          state_d = RUN;
          bub_d   = '0;
        end else begin
          bub_d = bub_q - 2'd1;
        end
      end else if (LU_BUBBLES > 1) begin
        state_d = LU_STALL;
        bub_d   = BUB_INIT;
      end
    end else if (!hz.ihit) begin
      hz.pc_en      = 1'b0;
      hz.ifid_flush = 1'b1;
    end

    if (nRST && state_q != HALTED && hz.halt) state_d = HALTED;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!hz.pc_en && state_q != HALTED && stall_q != '1) stall_q <= stall_q + 1'b1;
      if (flush_evt && flush_q != '1) flush_q <= flush_q + 1'b1;
    end
  end

  assign hz.state     = state_q;
  assign hz.stall_cnt = stall_q;
  assign hz.flush_cnt = flush_q;
endmodule
